wb_select_stage: RTL and testbench

Parametrised, pipelined write-back source selector for the pipelined MIPS datapath. It generalises the single-cycle two-way result muxes to `NUM_SRC` sources and selects the result in the cycle of acceptance. It registers the result together with its destination register and write-enable into a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between the MEM stage and the register-file write port and absorbs one cycle of back-pressure without a combinational ready path.

---
 rtl/wb_select_stage.sv | 167 ++++++++++++++++
 tb/tb_wb_select_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_select_stage
//  Purpose  : Write-back source selector for the pipelined MIPS datapath.
//             Picks one of NUM_SRC results on acceptance and stores it with
//             its destination register and write enable in a 2-entry skid
//             buffer (HEAD + SKID). in_ready is registered, so there is no
//             combinational path from out_ready back to the MEM stage.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_select_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int REG_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [REG_W-1:0]         in_dest,
    input  logic                     in_regwrite,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [REG_W-1:0]         out_dest,
    output logic                     out_regwrite,
    output logic                     sel_err,
    output logic [15:0]              retired
);

    // Occupancy states: number of stored entries.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // Select values at or above this bound are illegal.
    localparam logic [SEL_W:0] c_num_src = (SEL_W+1)'(NUM_SRC);
    localparam logic [15:0]    c_ret_max = 16'hFFFF;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_head_data;
    logic [REG_W-1:0] r_head_dest;
    logic             r_head_we;
    logic [WIDTH-1:0] r_skid_data;
    logic [REG_W-1:0] r_skid_dest;
    logic             r_skid_we;
    logic             r_sel_err;
    logic [15:0]      r_retired;

    logic             w_accept;
    logic             w_pop;
    logic             w_sel_ok;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_we;

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;
    assign w_sel_ok = ({1'b0, in_sel} < c_num_src);

    // Source mux; an out-of-range select matches no source and yields zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Writes to $zero and illegal selects must never reach the register file.
    assign w_we = in_regwrite && w_sel_ok && (in_dest != '0);

    // Occupancy FSM with HEAD/SKID storage; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head_data <= '0;
            r_head_dest <= '0;
            r_head_we   <= 1'b0;
            r_skid_data <= '0;
            r_skid_dest <= '0;
            r_skid_we   <= 1'b0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_head_data <= w_sel_data;
                        r_head_dest <= in_dest;
                        r_head_we   <= w_we;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_pop) begin
                        r_skid_data <= w_sel_data;
                        r_skid_dest <= in_dest;
                        r_skid_we   <= w_we;
                        r_state     <= S_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (!w_accept && w_pop) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept && w_pop) begin
                        r_head_data <= w_sel_data;
                        r_head_dest <= in_dest;
                        r_head_we   <= w_we;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head_data <= r_skid_data;
                        r_head_dest <= r_skid_dest;
                        r_head_we   <= r_skid_we;
                        r_state     <= S_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky illegal-select flag; a flushed accept never stored anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && !flush && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end
    end

    // Saturating pop counter; a pop coincident with flush still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_pop && (r_retired != c_ret_max)) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_head_data;
    assign out_dest     = r_head_dest;
    assign out_regwrite = r_head_we;
    assign sel_err      = r_sel_err;
    assign retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_select_stage
//  Purpose  : Self-checking bench for wb_select_stage. A queue-based model
//             tracks stored entries, the retired count and the error flag.
//             A second instance with NUM_SRC=3 covers illegal selects.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_select_stage;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  r;
        logic        w;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    // Main instance (NUM_SRC = 4)
    logic         flush, in_valid, in_ready, in_regwrite;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic [4:0]   in_dest;
    logic         out_valid, out_ready, out_regwrite, sel_err;
    logic [31:0]  out_data;
    logic [4:0]   out_dest;
    logic [15:0]  retired;
    // Second instance (NUM_SRC = 3)
    logic         flush_b, in_valid_b, in_ready_b, in_regwrite_b;
    logic [95:0]  in_data_b;
    logic [1:0]   in_sel_b;
    logic [4:0]   in_dest_b;
    logic         out_valid_b, out_ready_b, out_regwrite_b, sel_err_b;
    logic [31:0]  out_data_b;
    logic [4:0]   out_dest_b;
    logic [15:0]  retired_b;

    int           total = 0;
    int           bad   = 0;

    entry_t       m_q[$];
    logic [15:0]  m_ret;

    always #5 clk = ~clk;

    wb_select_stage #(.WIDTH(32), .NUM_SRC(4), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_dest(in_dest), .in_regwrite(in_regwrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_regwrite(out_regwrite),
        .sel_err(sel_err), .retired(retired)
    );

    wb_select_stage #(.WIDTH(32), .NUM_SRC(3), .REG_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_sel(in_sel_b), .in_dest(in_dest_b), .in_regwrite(in_regwrite_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_dest(out_dest_b), .out_regwrite(out_regwrite_b),
        .sel_err(sel_err_b), .retired(retired_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every main-instance output with the model's view.
    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0].d);
            chk("out_dest", 32'(out_dest), 32'(m_q[0].r));
            chk("out_regwrite", 32'(out_regwrite), 32'(m_q[0].w));
        end
        chk("sel_err", 32'(sel_err), 32'd0);
        chk("retired", 32'(retired), 32'(m_ret));
    endtask

    // Apply the handshake rules to the model for the edge just taken.
    task automatic model_update();
        bit     acc, pop;
        entry_t e;
        acc = in_valid && (m_q.size() < 2);
        pop = (m_q.size() != 0) && out_ready;
        if (pop && m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                e.d = in_data[int'(in_sel)*32 +: 32];
                e.r = in_dest;
                e.w = in_regwrite && (in_dest != 5'd0);
                m_q.push_back(e);
            end
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic step();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_rand_inputs();
        in_data     = {$urandom, $urandom, $urandom, $urandom};
        in_sel      = 2'($urandom_range(0, 3));
        in_dest     = 5'($urandom_range(0, 31));
        in_regwrite = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        logic [31:0] popped[$];
        logic [15:0] ret_before;
        int          obs_pops;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_sel = '0; in_dest = '0; in_regwrite = 1'b0;
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        in_data_b = '0; in_sel_b = '0; in_dest_b = '0; in_regwrite_b = 1'b0;
        m_q.delete(); m_ret = 16'd0;

        // Reset values on both instances
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_dest", 32'(out_dest), 32'd0);
        chk("rst_out_regwrite", 32'(out_regwrite), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_b_in_ready", 32'(in_ready_b), 32'd1);
        chk("rst_b_out_valid", 32'(out_valid_b), 32'd0);
        rst_n = 1'b1;

        // Single accept of the JAL source
        in_valid = 1'b1; in_sel = 2'd2; in_dest = 5'd31; in_regwrite = 1'b1;
        in_data = {32'h0, 32'h0040_0008, 32'h0, 32'h0};
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", out_data, 32'h0040_0008);
        chk("single_dest", 32'(out_dest), 32'd31);
        chk("single_we", 32'(out_regwrite), 32'd1);
        drain();

        // Back-pressure: four results, consumer stalled for three cycles
        ret_before = m_ret;
        in_data = {32'd4, 32'd3, 32'd2, 32'd1};
        in_regwrite = 1'b1;
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 16; cyc++) begin
                out_ready = (cyc >= 3);
                in_valid  = (idx < 4);
                in_sel    = 2'(idx);
                in_dest   = 5'(idx + 1);
                if (cyc == 2) chk("bp_full_in_ready", 32'(in_ready), 32'd0);
                if (out_valid && out_ready) popped.push_back(out_data);
                if (in_valid && m_q.size() < 2) idx++;
                step();
            end
        end
        chk("bp_count", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("bp_order", popped[i], 32'(i + 1));
        chk("bp_retired", 32'(retired), 32'(ret_before + 16'd4));

        // $zero suppression and illegal select on the 3-source instance
        in_valid_b = 1'b1; in_sel_b = 2'd1; in_dest_b = 5'd0; in_regwrite_b = 1'b1;
        in_data_b = {32'h1111_2222, 32'hAAAA_5555, 32'h3333_4444};
        step();
        chk("zero_valid", 32'(out_valid_b), 32'd1);
        chk("zero_data", out_data_b, 32'hAAAA_5555);
        chk("zero_we", 32'(out_regwrite_b), 32'd0);
        chk("zero_no_err", 32'(sel_err_b), 32'd0);
        in_sel_b = 2'd3; in_dest_b = 5'd7;
        step();
        in_valid_b = 1'b0;
        chk("badsel_valid", 32'(out_valid_b), 32'd1);
        chk("badsel_data", out_data_b, 32'd0);
        chk("badsel_dest", 32'(out_dest_b), 32'd7);
        chk("badsel_we", 32'(out_regwrite_b), 32'd0);
        chk("badsel_err", 32'(sel_err_b), 32'd1);
        repeat (3) step();
        chk("badsel_sticky", 32'(sel_err_b), 32'd1);
        chk("badsel_retired", 32'(retired_b), 32'd2);

        // Flush while full, with a coincident valid input
        out_ready = 1'b0; in_valid = 1'b1; in_regwrite = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = {4{32'hC0DE_0000 + 32'(i)}}; in_dest = 5'(i + 3);
            step();
        end
        chk("flush_pre_full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
            step();
        end

        // Randomised traffic with occasional flushes
        set_rand_inputs();
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && m_q.size() == 2)) begin
                set_rand_inputs();
                in_valid = 1'($urandom_range(0, 3) != 0);
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        drain();

        // Full throughput: 100 back-to-back accepts
        ret_before = m_ret;
        obs_pops = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_rand_inputs();
            if (out_valid && out_ready) obs_pops++;
            if (i > 0) chk("tput_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        if (out_valid) obs_pops++;
        step();
        chk("tput_pops", 32'(obs_pops), 32'd100);
        chk("tput_retired", 32'(retired), 32'(ret_before + 16'd100));
        drain();

        // Mid-operation reset drops entries without counting them
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_retired", 32'(retired), 32'd0);
        m_q.delete(); m_ret = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Counter saturation
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFE;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand_inputs();
            step();
        end
        drain();
        chk("sat_value", 32'(retired), 32'h0000_FFFF);
        repeat (2) step();
        chk("sat_hold", 32'(retired), 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
